// File: rtl/insn_mem_prog.sv
// rtl/insn_mem_prog.sv - synchronous-read instruction memory with a streaming program-load port
// Fetch returns one word per cycle in RUN; LOAD mode writes words sequentially from index 0.
module insn_mem_prog #(
  parameter int                DATA_W     = 32,
  parameter int                DEPTH      = 1024,
  parameter int                ADDR_W     = 32,
  parameter logic [DATA_W-1:0] RESET_INSN = DATA_W'(32'h00000013),
  localparam int               CW         = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] insn_out,
  output logic              fault_misalign,
  output logic              fault_range,
  input  logic              prog_en,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic [CW-1:0]     prog_count
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              IW      = ADDR_W - 2;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [IW-1:0]   DEPTH_I = IW'(DEPTH);

  typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]     wr_ptr_q;
  logic              prog_done_q;
  logic              fetch_valid_q;
  logic              fault_misalign_q;
  logic              fault_range_q;
  logic [DATA_W-1:0] insn_q;

  logic              wr_en;
  logic              fetch_acc;
  logic [IW-1:0]     word_idx;
  logic              misalign;
  logic              out_of_range;

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (prog_en)  state_d = LOAD;
      LOAD:    if (!prog_en) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    fetch_ready = (state_q == RUN);
    prog_ready  = (state_q == LOAD) && (wr_ptr_q < DEPTH_C);
  end

  assign wr_en        = prog_valid && prog_ready;
  assign fetch_acc    = fetch_req && fetch_ready;
  assign word_idx     = fetch_addr[ADDR_W-1:2];
  assign misalign     = (fetch_addr[1:0] != 2'b00);
  assign out_of_range = (word_idx >= DEPTH_I);

  // Array has no reset so a reset mid-load keeps the words already written.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr_q[AW-1:0]] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q         <= '0;
      prog_done_q      <= 1'b0;
      fetch_valid_q    <= 1'b0;
      fault_misalign_q <= 1'b0;
      fault_range_q    <= 1'b0;
      insn_q           <= RESET_INSN;
    end else begin
      prog_done_q <= (state_q == LOAD) && !prog_en;
      if (state_q == RUN && prog_en) wr_ptr_q <= '0;
      else if (wr_en)                wr_ptr_q <= wr_ptr_q + CW'(1);

      fetch_valid_q    <= fetch_acc;
      fault_misalign_q <= fetch_acc && misalign;
      fault_range_q    <= fetch_acc && out_of_range;
      // The array index is only meaningful when the range check passed.
      if (fetch_acc) begin
        if (misalign || out_of_range) insn_q <= RESET_INSN;
        else                          insn_q <= mem[word_idx[AW-1:0]];
      end
    end
  end

  assign fetch_valid    = fetch_valid_q;
  assign insn_out       = insn_q;
  assign fault_misalign = fault_misalign_q;
  assign fault_range    = fault_range_q;
  assign prog_done      = prog_done_q;
  assign prog_count     = wr_ptr_q;

endmodule
